// File: rtl/displacement_immediate_encoder.sv
// displacement_immediate_encoder
//
// Serializes the displacement and immediate fields of one instruction record
// into a little-endian byte stream. A record is latched in IDLE, then the
// displacement bytes are emitted (byte 0 first), then the immediate bytes.
// Each field has a one-hot length: bit0 = 1 byte, bit1 = 2, bit2 = 4, bit3 = 4.
// The lowest set bit wins. An absent field or a zero length gives no bytes.
//
// Ports
//   clock                    rising-edge clock
//   reset_n                  asynchronous active-low reset
//   in_valid / in_ready      record handshake (in_ready only in IDLE)
//   displacement_is_present  displacement field exists
//   displacement_length      one-hot length of displacement
//   displacement             displacement value (low bytes used)
//   immediate_is_present     immediate field exists
//   immediate_length         one-hot length of immediate
//   immediate                immediate value (low bytes used)
//   out_valid / out_ready    byte stream handshake
//   out_byte                 serialized byte (8'h00 when out_valid = 0)
//   out_field                0 = displacement byte, 1 = immediate byte
//   out_last                 final byte of the record
//   done                     one-cycle pulse when a record completes
module displacement_immediate_encoder (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        displacement_is_present,
  input  logic [3:0]  displacement_length,
  input  logic [31:0] displacement,
  input  logic        immediate_is_present,
  input  logic [3:0]  immediate_length,
  input  logic [31:0] immediate,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_field,
  output logic        out_last,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, DISP, IMM} state_t;

  state_t      state;
  logic [31:0] disp_q;
  logic [31:0] imm_q;
  logic [2:0]  disp_cnt;
  logic [2:0]  imm_cnt;
  logic [1:0]  byte_idx;

  logic [2:0]  disp_bytes_in;
  logic [2:0]  imm_bytes_in;
  logic [2:0]  idx_plus1;
  logic [2:0]  idx_plus2;
  logic [1:0]  next_idx;

  // Byte count of a field; the lowest set length bit decides.
  function automatic logic [2:0] field_bytes(input logic present, input logic [3:0] len);
    if (!present)   return 3'd0;
    else if (len[0]) return 3'd1;
    else if (len[1]) return 3'd2;
    else if (len[2]) return 3'd4;
    else if (len[3]) return 3'd4;
    else            return 3'd0;
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] data, input logic [1:0] idx);
    case (idx)
      2'd0:    return data[7:0];
      2'd1:    return data[15:8];
      2'd2:    return data[23:16];
      default: return data[31:24];
    endcase
  endfunction

  assign disp_bytes_in = field_bytes(displacement_is_present, displacement_length);
  assign imm_bytes_in  = field_bytes(immediate_is_present, immediate_length);
  assign idx_plus1     = {1'b0, byte_idx} + 3'd1;
  assign idx_plus2     = {1'b0, byte_idx} + 3'd2;
  assign next_idx      = byte_idx + 2'd1;

  // Accepting only in IDLE means no record can be taken during a final transfer.
  assign in_ready = (state == IDLE);

  // Single FSM register block: all outputs are registered so that out_byte,
  // out_field and out_last hold steady while the consumer stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      disp_q    <= 32'h0;
      imm_q     <= 32'h0;
      disp_cnt  <= 3'd0;
      imm_cnt   <= 3'd0;
      byte_idx  <= 2'd0;
      out_valid <= 1'b0;
      out_byte  <= 8'h00;
      out_field <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            disp_q   <= displacement;
            imm_q    <= immediate;
            disp_cnt <= disp_bytes_in;
            imm_cnt  <= imm_bytes_in;
            byte_idx <= 2'd0;
            if (disp_bytes_in != 3'd0) begin
              state     <= DISP;
              out_valid <= 1'b1;
              out_byte  <= displacement[7:0];
              out_field <= 1'b0;
              out_last  <= (disp_bytes_in == 3'd1) && (imm_bytes_in == 3'd0);
            end else if (imm_bytes_in != 3'd0) begin
              state     <= IMM;
              out_valid <= 1'b1;
              out_byte  <= immediate[7:0];
              out_field <= 1'b1;
              out_last  <= (imm_bytes_in == 3'd1);
            end else begin
              // Empty record: nothing to emit, just report completion.
              done <= 1'b1;
            end
          end
        end

        DISP: begin
          if (out_ready) begin
            if (idx_plus1 < disp_cnt) begin
              byte_idx <= next_idx;
              out_byte <= pick_byte(disp_q, next_idx);
              out_last <= (idx_plus2 == disp_cnt) && (imm_cnt == 3'd0);
            end else if (imm_cnt != 3'd0) begin
              // Move straight into the immediate with no idle cycle.
              state     <= IMM;
              byte_idx  <= 2'd0;
              out_byte  <= imm_q[7:0];
              out_field <= 1'b1;
              out_last  <= (imm_cnt == 3'd1);
            end else begin
              state     <= IDLE;
              byte_idx  <= 2'd0;
              out_valid <= 1'b0;
              out_byte  <= 8'h00;
              out_field <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end
          end
        end

        IMM: begin
          if (out_ready) begin
            if (idx_plus1 < imm_cnt) begin
              byte_idx <= next_idx;
              out_byte <= pick_byte(imm_q, next_idx);
              out_last <= (idx_plus2 == imm_cnt);
            end else begin
              state     <= IDLE;
              byte_idx  <= 2'd0;
              out_valid <= 1'b0;
              out_byte  <= 8'h00;
              out_field <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_byte  <= 8'h00;
          out_field <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/displacement_immediate_encoder.md
DISPLACEMENT_IMMEDIATE_ENCODER -- requirements
Module: displacement_immediate_encoder

Interface
REQ-001 SHALL provide: clock  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide: in_valid  input  1  a field record is offered.
REQ-004 SHALL provide: in_ready  output  1  record may be accepted this cycle.
REQ-005 SHALL provide: displacement_is_present  input  1  displacement field exists.
REQ-006 SHALL provide: displacement_length  input  4  one-hot: bit0 8-bit, bit1 16-bit, bit2 32-bit, bit3 full (32-bit).
REQ-007 SHALL provide: displacement  input  32  displacement value, low bytes used.
REQ-008 SHALL provide: immediate_is_present  input  1  immediate field exists.
REQ-009 SHALL provide: immediate_length  input  4  one-hot, same encoding as displacement_length.
REQ-010 SHALL provide: immediate  input  32  immediate value, low bytes used.
REQ-011 SHALL provide: out_valid  output  1  out_byte is valid.
REQ-012 SHALL provide: out_ready  input  1  consumer accepts out_byte.
REQ-013 SHALL provide: out_byte  output  8  serialized instruction byte.
REQ-014 SHALL provide: out_field  output  1  0 = displacement byte, 1 = immediate byte.
REQ-015 SHALL provide: out_last  output  1  out_byte is final byte of the record.
REQ-016 SHALL provide: done  output  1  one-cycle pulse when a record completes.

Function
REQ-017 Byte count per field SHALL be 0 if is_present=0, else 1/2/4/4 for length bit0/1/2/3; lowest set bit wins; length 4'b0000 with is_present=1 SHALL give 0 bytes.
REQ-018 States SHALL be IDLE, DISP, IMM; in_ready SHALL be 1 only in IDLE.
REQ-019 On in_valid & in_ready, all inputs SHALL be latched; later input changes SHALL not affect the record.
REQ-020 From IDLE on accept: to DISP if disp count>0, else IMM if imm count>0, else stay IDLE and pulse done next cycle with no out_valid.
REQ-021 out_valid SHALL assert the cycle after acceptance (registered output); in_valid to first out_valid latency = 1 cycle.
REQ-022 Bytes SHALL be emitted little-endian: displacement byte 0 first, all displacement bytes, then immediate byte 0 upward.
REQ-023 A byte transfers on out_valid & out_ready; out_byte, out_field, out_last SHALL hold stable while out_valid & !out_ready.
REQ-024 With out_ready held 1, one byte SHALL transfer per cycle with no gap between DISP and IMM.
REQ-025 A 2-bit byte index SHALL reset to 0 on entry to each field and increment per transfer.
REQ-026 out_last SHALL be 1 exactly on the final byte of the record (last disp byte if imm count=0).
REQ-027 After final transfer: state IDLE, out_valid 0, done 1 for one cycle, in_ready 1 in that same next cycle; no same-cycle accept during the final transfer.
REQ-028 An n-byte record SHALL occupy n+1 cycles from acceptance to next possible acceptance when out_ready=1.
REQ-029 out_byte SHALL be 8'h00 whenever out_valid=0.

Reset
REQ-030 reset_n=0 SHALL immediately force: state IDLE, in_ready 1, out_valid 0, out_byte 8'h00, out_field 0, out_last 0, done 0, byte index 0, latched fields 0.
REQ-031 Reset asserted mid-record SHALL discard the record; no further bytes or done pulse for it after release.
REQ-032 First acceptance SHALL be possible on the first rising edge after reset_n deasserts.

Verification
REQ-033 disp present len 4'b0100 = 32'h1122_3344, imm present len 4'b0001 = 32'h0000_00AB, out_ready=1 -> bytes 44,33,22,11 (field 0), AB (field 1, last), done next cycle.
REQ-034 disp absent, imm len 4'b0010 = 32'h0000_BEEF -> EF then BE (last), field 1 both; 3 cycles accept-to-accept.
REQ-035 Both absent -> no out_valid, done pulse 1 cycle after accept, in_ready stays 1.
REQ-036 disp len 4'b0010 = 16'h5A6B, out_ready toggled 0/1 per cycle -> 6B held during stall, then 5A last, no byte dropped or duplicated.
REQ-037 disp len 4'b1000 = 32'hDEAD_BEEF, reset_n low after 2nd byte -> outputs at reset values immediately; after release no AD/DE emitted, in_ready=1.
REQ-038 Input buses changed every cycle after accept -> emitted bytes match values latched at accept.
